// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: ball motion, paddle hit/miss, scoring and the 2-bit game state.
// Optional build macro SPEEDUP_EN: every fourth paddle hit speeds the ball up horizontally.
module pong_game_ctrl #(
  parameter int PAD1_X      = 20,
  parameter int PAD2_X      = 620,
  parameter int PAD_HALF    = 50,
  parameter int Y_MAX       = 479,
  parameter int CENTER_X    = 320,
  parameter int CENTER_Y    = 240,
  parameter int BALL_STEP_X = 4,
  parameter int BALL_STEP_Y = 2,
  parameter int WIN_SCORE   = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic [9:0] pad1_y,
  input  logic [9:0] pad2_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [1:0] state,
  output logic       point_p1,
  output logic       point_p2
);

  typedef enum logic [1:0] {
    QI      = 2'b00,
    QGAME_1 = 2'b01,
    QGAME_2 = 2'b10,
    QDONE   = 2'b11
  } state_t;

  localparam logic signed [11:0] PAD1_S  = 12'(PAD1_X);
  localparam logic signed [11:0] PAD2_S  = 12'(PAD2_X);
  localparam logic signed [11:0] HALF_S  = 12'(PAD_HALF);
  localparam logic signed [11:0] YMAX_S  = 12'(Y_MAX);
  localparam logic signed [11:0] STEPY_S = 12'(BALL_STEP_Y);

  function automatic logic signed [11:0] s12(input logic [9:0] v);
    return $signed({2'b00, v});
  endfunction

  // Paddle window evaluated signed so a paddle near row 0 does not wrap.
  function automatic logic in_window(input logic [9:0] by, input logic [9:0] pad);
    logic signed [11:0] y;
    logic signed [11:0] p;
    y = s12(by);
    p = s12(pad);
    return (y >= p - HALF_S) && (y <= p + HALF_S);
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= 4'(WIN_SCORE)) ? s : s + 4'd1;
  endfunction

  state_t             st_q, st_d;
  logic [9:0]         bx_d, by_d;
  logic [3:0]         p1_d, p2_d;
  logic               pt1_d, pt2_d;
  logic               dy_down_q, dy_down_d;
  logic [3:0]         step_x;
  logic               move_left, reached, pad_hit, wall_hi, wall_lo;
  logic signed [11:0] nx, ny;
  logic [9:0]         vy_next;
  logic               vdy_next;

`ifdef SPEEDUP_EN
  logic [1:0] hits_q, hits_d;
  logic [3:0] step_q, step_d;
  assign step_x = step_q;
`else
  assign step_x = 4'(BALL_STEP_X);
`endif

  assign state     = st_q;
  assign move_left = (st_q == QGAME_1);
  assign nx        = move_left ? s12(ball_x) - s12({6'b0, step_x})
                               : s12(ball_x) + s12({6'b0, step_x});
  assign reached   = move_left ? (nx <= PAD1_S) : (nx >= PAD2_S);
  assign pad_hit   = in_window(ball_y, move_left ? pad1_y : pad2_y);

  assign ny        = dy_down_q ? s12(ball_y) + STEPY_S : s12(ball_y) - STEPY_S;
  assign wall_hi   = dy_down_q && (ny >= YMAX_S);
  assign wall_lo   = !dy_down_q && (ny <= 12'sd0);
  assign vy_next   = wall_hi ? 10'(Y_MAX) : (wall_lo ? 10'd0 : ny[9:0]);
  assign vdy_next  = (wall_hi || wall_lo) ? ~dy_down_q : dy_down_q;

  always_comb begin
    st_d      = st_q;
    bx_d      = ball_x;
    by_d      = ball_y;
    p1_d      = p1_score;
    p2_d      = p2_score;
    pt1_d     = 1'b0;
    pt2_d     = 1'b0;
    dy_down_d = dy_down_q;
`ifdef SPEEDUP_EN
    hits_d    = hits_q;
    step_d    = step_q;
`endif
    case (st_q)
      QI: begin
        bx_d      = 10'(CENTER_X);
        by_d      = 10'(CENTER_Y);
        dy_down_d = 1'b1;
        if (start) begin
          st_d = QGAME_1;
          p1_d = 4'd0;
          p2_d = 4'd0;
`ifdef SPEEDUP_EN
          hits_d = 2'd0;
          step_d = 4'(BALL_STEP_X);
`endif
        end
      end
      QGAME_1, QGAME_2: begin
        if (tick && start) begin
          if (!reached) begin
            bx_d      = nx[9:0];
            by_d      = vy_next;
            dy_down_d = vdy_next;
          end else if (pad_hit) begin
            bx_d      = move_left ? 10'(PAD1_X) : 10'(PAD2_X);
            st_d      = move_left ? QGAME_2 : QGAME_1;
            by_d      = vy_next;
            dy_down_d = vdy_next;
`ifdef SPEEDUP_EN
            hits_d = hits_q + 2'd1;
            if (hits_q == 2'd3 && step_q < 4'(2 * BALL_STEP_X))
              step_d = step_q + 4'd1;
`endif
          end else begin
            // Miss: centre reload overrides vertical motion, dy is kept.
            bx_d = 10'(CENTER_X);
            by_d = 10'(CENTER_Y);
`ifdef SPEEDUP_EN
            hits_d = 2'd0;
            step_d = 4'(BALL_STEP_X);
`endif
            if (move_left) begin
              p2_d  = sat_inc(p2_score);
              pt2_d = 1'b1;
              if (p2_d == 4'(WIN_SCORE)) st_d = QDONE;
            end else begin
              p1_d  = sat_inc(p1_score);
              pt1_d = 1'b1;
              if (p1_d == 4'(WIN_SCORE)) st_d = QDONE;
            end
          end
        end
      end
      default: begin
        bx_d = 10'(CENTER_X);
        by_d = 10'(CENTER_Y);
        if (!start) st_d = QI;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q      <= QI;
      ball_x    <= 10'(CENTER_X);
      ball_y    <= 10'(CENTER_Y);
      p1_score  <= 4'd0;
      p2_score  <= 4'd0;
      point_p1  <= 1'b0;
      point_p2  <= 1'b0;
      dy_down_q <= 1'b1;
`ifdef SPEEDUP_EN
      hits_q    <= 2'd0;
      step_q    <= 4'(BALL_STEP_X);
`endif
    end else begin
      st_q      <= st_d;
      ball_x    <= bx_d;
      ball_y    <= by_d;
      p1_score  <= p1_d;
      p2_score  <= p2_d;
      point_p1  <= pt1_d;
      point_p2  <= pt2_d;
      dy_down_q <= dy_down_d;
`ifdef SPEEDUP_EN
      hits_q    <= hits_d;
      step_q    <= step_d;
`endif
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: directed serve/hit, idle, async reset,
// and long randomized play compared every cycle against a behavioural game model.
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic [9:0] pad1_y = 10'd240;
  logic [9:0] pad2_y = 10'd240;
  logic [9:0] ball_x, ball_y;
  logic [3:0] p1_score, p2_score;
  logic [1:0] state;
  logic       point_p1, point_p2;

  pong_game_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .start    (start),
    .pad1_y   (pad1_y),
    .pad2_y   (pad2_y),
    .ball_x   (ball_x),
    .ball_y   (ball_y),
    .p1_score (p1_score),
    .p2_score (p2_score),
    .state    (state),
    .point_p1 (point_p1),
    .point_p2 (point_p2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Game model: mode 0 idle, 1 ball heading left, 2 heading right, 3 game over.
  int m_st, m_x, m_y, m_dy, m_p1, m_p2, m_pt1, m_pt2, m_step, m_hits;

  task automatic model_reset();
    m_st = 0; m_x = 320; m_y = 240; m_dy = 1;
    m_p1 = 0; m_p2 = 0; m_pt1 = 0; m_pt2 = 0;
    m_step = 4; m_hits = 0;
  endtask

  task automatic model_vert();
    int ny;
    ny = m_y + 2 * m_dy;
    if (m_dy > 0 && ny >= 479) begin
      m_y = 479; m_dy = -1;
    end else if (m_dy < 0 && ny <= 0) begin
      m_y = 0; m_dy = 1;
    end else begin
      m_y = ny;
    end
  endtask

  task automatic model_step();
    int  nx, pad;
    bit  left, reached;
    m_pt1 = 0;
    m_pt2 = 0;
    case (m_st)
      0: begin
        m_x = 320; m_y = 240; m_dy = 1;
        if (start) begin
          m_st = 1; m_p1 = 0; m_p2 = 0; m_step = 4; m_hits = 0;
        end
      end
      1, 2: begin
        if (tick && start) begin
          left    = (m_st == 1);
          nx      = left ? m_x - m_step : m_x + m_step;
          reached = left ? (nx <= 20) : (nx >= 620);
          pad     = left ? int'(pad1_y) : int'(pad2_y);
          if (!reached) begin
            m_x = nx;
            model_vert();
          end else if (m_y >= pad - 50 && m_y <= pad + 50) begin
            m_x  = left ? 20 : 620;
            m_st = left ? 2 : 1;
            model_vert();
`ifdef SPEEDUP_EN
            m_hits = (m_hits + 1) % 4;
            if (m_hits == 0 && m_step < 8) m_step++;
`endif
          end else begin
            m_x = 320; m_y = 240; m_step = 4; m_hits = 0;
            if (left) begin
              m_p2  = (m_p2 < 10) ? m_p2 + 1 : 10;
              m_pt2 = 1;
              if (m_p2 == 10) m_st = 3;
            end else begin
              m_p1  = (m_p1 < 10) ? m_p1 + 1 : 10;
              m_pt1 = 1;
              if (m_p1 == 10) m_st = 3;
            end
          end
        end
      end
      default: begin
        m_x = 320; m_y = 240;
        if (!start) m_st = 0;
      end
    endcase
  endtask

  task automatic check_all();
    check_eq("state", state, m_st);
    check_eq("ball_x", ball_x, m_x);
    check_eq("ball_y", ball_y, m_y);
    check_eq("p1_score", p1_score, m_p1);
    check_eq("p2_score", p2_score, m_p2);
    check_eq("point_p1", point_p1, m_pt1);
    check_eq("point_p2", point_p2, m_pt2);
  endtask

  task automatic check_reset_values(input string pfx);
    check_eq({pfx, "_state"}, state, 0);
    check_eq({pfx, "_ball_x"}, ball_x, 320);
    check_eq({pfx, "_ball_y"}, ball_y, 240);
    check_eq({pfx, "_p1"}, p1_score, 0);
    check_eq({pfx, "_p2"}, p2_score, 0);
    check_eq({pfx, "_pt1"}, point_p1, 0);
    check_eq({pfx, "_pt2"}, point_p2, 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    int prev_st;
    int wins;
    wins = 0;

    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    // Ticks with start low must not move anything.
    for (int i = 0; i < 100; i++) begin
      tick = 1'b1;
      start = 1'b0;
      cycle();
    end
    check_eq("idle_ball_x", ball_x, 320);
    check_eq("idle_state", state, 0);

    // Serve, then 75 ticks to reach the left plane with the paddle on the ball.
    start = 1'b1;
    tick = 1'b1;
    pad1_y = 10'd388;
    pad2_y = 10'd240;
    for (int i = 0; i < 76; i++) cycle();
    check_eq("hit_ball_x", ball_x, 20);
    check_eq("hit_ball_y", ball_y, 390);
    check_eq("hit_state", state, 2);

    for (int i = 0; i < 30000; i++) begin
      tick   = 1'($urandom_range(0, 1));
      start  = ($urandom_range(0, 99) < 94);
      pad1_y = 10'($urandom_range(0, 479));
      pad2_y = 10'($urandom_range(0, 479));
      prev_st = m_st;
      cycle();
      if (prev_st != 3 && m_st == 3) begin
        wins++;
        check_eq("win_score", (p1_score > p2_score) ? p1_score : p2_score, 10);
        check_eq("win_state", state, 3);
      end
      if (i == 15000) begin
        // Asynchronous reset between clock edges.
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("async");
        model_reset();
        @(negedge clk);
        reset = 1'b1;
      end
    end

    if (wins == 0)
      $display("note: randomized run reached no game-over state");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
